snitch_msip_sequencer: RTL
==========================

// Module: snitch_msip_sequencer
// PURPOSE
// - Hardware replacement for the DPI CLINT tick in the cluster testbench.
// - Drives the per-hart software-interrupt vector (msip_i of the cluster wrapper).
// - Accepts set/clear/broadcast commands over a valid/ready port.
// - Broadcast wakes harts in ascending order with a programmable cycle gap, so harts
//   do not hit the narrow/wide memory ports in the same cycle after wake-up.
// PARAMETERS
// - NrCores   9  number of harts driven; must be >= 1
// - GapWidth  8  width of the inter-hart gap counter
// - HartWidth derived: (NrCores > 1) ? $clog2(NrCores) : 1; not overridable
// PORTS
// - clk_i        in   1          clock
// - rst_ni       in   1          reset, asynchronous, active-low
// - req_valid_i  in   1          command valid
// - req_ready_o  out  1          command ready
// - req_op_i     in   2          0 SET hart, 1 CLR hart, 2 BCAST wake, 3 CLR_ALL
// - req_hart_i   in   HartWidth  target hart for SET/CLR
// - req_gap_i    in   GapWidth   idle cycles between successive BCAST sets
// - abort_i      in   1          cancel broadcast and clear all msip
// - msip_o       out  NrCores    per-hart software interrupt
// - busy_o       out  1          broadcast in progress
// - err_o        out  1          one-cycle pulse: SET/CLR hart >= NrCores
// - wake_cnt_o   out  16         completed broadcasts (only with macro, see CONFIGURATION)
// BEHAVIOUR
// - Reset values: msip_o=0, busy_o=0, err_o=0, wake_cnt_o=0, FSM=IDLE, idx=0, gap cnt=0.
// - Handshake: command accepted on the cycle req_valid_i && req_ready_o.
// - req_ready_o = (state==IDLE) && !abort_i.
// - req_* must stay stable while valid && !ready.
// - All outputs are registered. Effect of an accepted command is visible on the next cycle.
// - SET/CLR: set or clear msip_o[req_hart_i]; other bits unchanged.
//   - If req_hart_i >= NrCores: msip_o unchanged, err_o=1 for exactly 1 cycle. The command still completes.
// - CLR_ALL: msip_o <= 0.
// - BCAST: latch req_gap_i, idx <= 0, go to WAKE.
// - FSM IDLE/WAKE/GAP:
//   - WAKE: msip_o[idx] <= 1 (bit already set stays set).
//     - If idx == NrCores-1: go to IDLE and increment wake_cnt.
//     - Else if gap == 0: idx++, stay in WAKE (one hart per cycle).
//     - Else: idx++, cnt <= gap-1, go to GAP.
//   - GAP: if cnt == 0 go to WAKE, else cnt--.
// - Timing: for hart k, msip_o[k] rises exactly 1 + k*(gap+1) cycles after acceptance.
// - busy_o = (state != IDLE).
// - A BCAST with NrCores=1 sets bit 0 and returns to IDLE after one WAKE cycle.
// - abort_i (any state): next cycle msip_o=0, FSM=IDLE, idx=0. wake_cnt is not incremented.
//   - No command is accepted in the abort cycle.
//   - If abort_i coincides with the final WAKE cycle, abort wins and the broadcast is not counted.
// - Async reset mid-broadcast: immediately returns to reset values. No partial state is retained.
// - gap arithmetic is unsigned GapWidth bits; max gap = 2^GapWidth-1 cycles.
// - wake_cnt saturates at 16'hFFFF (no wrap).
// CONFIGURATION
// - SNITCH_MSIP_SEQ_STATS_EN defined:
//   - wake_cnt_o port present.
//   - 16-bit saturating counter of broadcasts that reached completion without abort.
// - SNITCH_MSIP_SEQ_STATS_EN undefined:
//   - wake_cnt_o port and counter absent.
//   - All other behaviour identical.
// TESTING (NrCores=9, GapWidth=8 unless stated)
// - Reset: after rst_ni release -> msip_o=0, busy_o=0, req_ready_o=1, err_o=0.
// - SET hart 3 then CLR hart 3 -> msip_o=9'h008 one cycle after 1st accept, 9'h000 after 2nd.
// - SET hart 12 -> msip_o unchanged, err_o high exactly 1 cycle, ready stays 1.
// - BCAST gap=2 -> msip_o[k] rises at cycle 1+3k after accept (hart 8 at cycle 25).
//   - busy_o drops the cycle after, ready=0 throughout, wake_cnt_o=1.
// - BCAST gap=0 -> one new bit per cycle; msip_o=9'h1FF 9 cycles after accept.
// - BCAST gap=5, abort_i at cycle 8 -> msip_o=0 and IDLE next cycle, wake_cnt_o unchanged.
//   - A valid request held during the abort cycle is accepted only on the following cycle.

Source files
------------

// File: rtl/snitch_msip_sequencer.sv
// Per-hart msip driver: SET/CLR/CLR_ALL commands and staggered broadcast wake (optional stats: SNITCH_MSIP_SEQ_STATS_EN).
// Latency: command effect visible 1 cycle after accept; broadcast hart k rises 1 + k*(gap+1) cycles after accept.
// Backpressure: req_ready_o low while a broadcast is in flight or abort_i is high.
module snitch_msip_sequencer #(
    parameter int unsigned NrCores  = 9,
    parameter int unsigned GapWidth = 8,
    localparam int unsigned HartWidth = (NrCores > 1) ? $clog2(NrCores) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [1:0]           req_op_i,
    input  logic [HartWidth-1:0] req_hart_i,
    input  logic [GapWidth-1:0]  req_gap_i,
    input  logic                 abort_i,
    output logic [NrCores-1:0]   msip_o,
    output logic                 busy_o,
    output logic                 err_o
`ifdef SNITCH_MSIP_SEQ_STATS_EN
    ,
    output logic [15:0]          wake_cnt_o
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAKE = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam logic [1:0] OP_SET     = 2'd0;
    localparam logic [1:0] OP_CLR     = 2'd1;
    localparam logic [1:0] OP_BCAST   = 2'd2;
    localparam logic [1:0] OP_CLR_ALL = 2'd3;

    localparam logic [HartWidth:0]   NrCoresW = (HartWidth+1)'(NrCores);
    localparam logic [HartWidth-1:0] LastIdx  = HartWidth'(NrCores - 1);

    state_e                state_q, state_d;
    logic [HartWidth-1:0]  idx_q, idx_d;
    logic [GapWidth-1:0]   cnt_q, cnt_d;
    logic [GapWidth-1:0]   gap_q, gap_d;
    logic [NrCores-1:0]    msip_q, msip_d;
    logic                  err_q, err_d;
    logic                  bcast_done;
    logic                  accept;
    logic                  hart_ok;

    function automatic logic [NrCores-1:0] hart_bit(input logic [HartWidth-1:0] h);
        hart_bit = '0;
        for (int unsigned i = 0; i < NrCores; i++) begin
            if (h == HartWidth'(i)) hart_bit[i] = 1'b1;
        end
    endfunction

    assign req_ready_o = (state_q == IDLE) && !abort_i;
    assign accept      = req_valid_i && req_ready_o;
    assign hart_ok     = {1'b0, req_hart_i} < NrCoresW;

    // The msip bit of a hart is set on entry to WAKE so it is already visible
    // during that WAKE cycle; this keeps hart k at exactly 1 + k*(gap+1).
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        msip_d     = msip_q;
        err_d      = 1'b0;
        bcast_done = 1'b0;

        if (abort_i) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
            msip_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        unique case (req_op_i)
                            OP_SET: begin
                                if (hart_ok) msip_d = msip_q | hart_bit(req_hart_i);
                                else         err_d  = 1'b1;
                            end
                            OP_CLR: begin
                                if (hart_ok) msip_d = msip_q & ~hart_bit(req_hart_i);
                                else         err_d  = 1'b1;
                            end
                            OP_BCAST: begin
                                gap_d   = req_gap_i;
                                idx_d   = '0;
                                state_d = WAKE;
                                msip_d  = msip_q | hart_bit('0);
                            end
                            OP_CLR_ALL: msip_d = '0;
                            default: ;
                        endcase
                    end
                end
                WAKE: begin
                    if (idx_q == LastIdx) begin
                        state_d    = IDLE;
                        idx_d      = '0;
                        bcast_done = 1'b1;
                    end else if (gap_q == '0) begin
                        idx_d  = idx_q + HartWidth'(1);
                        msip_d = msip_q | hart_bit(idx_q + HartWidth'(1));
                    end else begin
                        idx_d   = idx_q + HartWidth'(1);
                        cnt_d   = gap_q - GapWidth'(1);
                        state_d = GAP;
                    end
                end
                GAP: begin
                    if (cnt_q == '0) begin
                        state_d = WAKE;
                        msip_d  = msip_q | hart_bit(idx_q);
                    end else begin
                        cnt_d = cnt_q - GapWidth'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            msip_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            msip_q  <= msip_d;
            err_q   <= err_d;
        end
    end

    assign msip_o = msip_q;
    assign busy_o = (state_q != IDLE);
    assign err_o  = err_q;

`ifdef SNITCH_MSIP_SEQ_STATS_EN
    logic [15:0] wake_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wake_cnt_q <= '0;
        end else if (bcast_done && (wake_cnt_q != 16'hFFFF)) begin
            wake_cnt_q <= wake_cnt_q + 16'd1;
        end
    end

    assign wake_cnt_o = wake_cnt_q;
`else
    logic unused_bcast_done;
    assign unused_bcast_done = bcast_done;
`endif

endmodule
